// File: rtl/out_stream_unpacker_pkg.sv
// Shared types and default geometry for the output stream unpacker.
package out_stream_unpacker_pkg;

  localparam int unsigned DEF_IO_DATA_WIDTH = 8;
  localparam int unsigned DEF_MEM_BW        = 128;
  localparam int unsigned NB_LANES          = DEF_MEM_BW / DEF_IO_DATA_WIDTH;
  localparam int unsigned LANE_IDX_W        = $clog2(NB_LANES);

  typedef enum logic {IDLE, SHIFT} unpack_state_t;

  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/unpacker_word_fifo.sv
// Word FIFO between the chip output capture and the unpacker holding register.
module unpacker_word_fifo #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      head_word,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr;
  logic [LOG2_DEPTH:0] rd_ptr;

  // Extra pointer MSB separates full from empty when the indices coincide.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
    count     = wr_ptr - rd_ptr;
    head_word = mem[rd_ptr[LOG2_DEPTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/out_stream_unpacker.sv
// Captures packed chip output words (no backpressure) and unpacks them into a
// byte stream with valid/ready; words that find the FIFO full are counted as dropped.
module out_stream_unpacker
  import out_stream_unpacker_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH  = DEF_IO_DATA_WIDTH,
  parameter int unsigned MEM_BW         = DEF_MEM_BW,
  parameter int unsigned LOG2_OF_DEPTH  = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arst_in,
  input  logic [MEM_BW-1:0]         out_word,
  input  logic                      output_valid,
  output logic [IO_DATA_WIDTH-1:0]  byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      byte_last,
  output logic [LOG2_OF_DEPTH:0]    fill_level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count,
  input  logic                      clear_overflow
);

  localparam int unsigned LANES = MEM_BW / IO_DATA_WIDTH;
  localparam int unsigned IDX_W = lane_idx_width(LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  unpack_state_t       state_q, state_d;
  logic [MEM_BW-1:0]   hold_q;
  logic [IDX_W-1:0]    lane_q;
  logic [MEM_BW-1:0]   fifo_head;
  logic                fifo_full, fifo_empty;
  logic                pop, push, drop, accept, last_accept;
  logic [IO_DATA_WIDTH-1:0] lane_data;

  unpacker_word_fifo #(
    .WIDTH      (MEM_BW),
    .LOG2_DEPTH (LOG2_OF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (arst_in),
    .wr_en     (push),
    .wr_data   (out_word),
    .rd_en     (pop),
    .head_word (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );

  always_comb begin
    accept      = (state_q == SHIFT) && byte_ready;
    last_accept = accept && (lane_q == LAST_LANE);
    state_d     = state_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_accept) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop on the same edge frees the slot a full FIFO needs for the new word.
    push = output_valid && (!fifo_full || pop);
    drop = output_valid && !push;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      hold_q <= '0;
      lane_q <= '0;
    end else if (pop) begin
      hold_q <= fifo_head;
      lane_q <= '0;
    end else if (accept) begin
      lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)            dropped_count <= DROP_CNT_WIDTH'(1);
      else if (dropped_count != '1)  dropped_count <= dropped_count + DROP_CNT_WIDTH'(1);
    end else if (clear_overflow) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end
  end

  always_comb begin
    lane_data  = hold_q[lane_q*IO_DATA_WIDTH +: IO_DATA_WIDTH];
    byte_valid = (state_q == SHIFT);
    byte_out   = byte_valid ? lane_data : '0;
    byte_last  = byte_valid && (lane_q == LAST_LANE);
  end

endmodule

// File: tb/tb_out_stream_unpacker.sv
// Randomized and directed checks of out_stream_unpacker against a queue-based reference model.
module tb_out_stream_unpacker;

  localparam int unsigned W     = 8;
  localparam int unsigned BW    = 128;
  localparam int unsigned L2D   = 4;
  localparam int unsigned DCW   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LANES = 16;

  logic           clk = 1'b0;
  logic           arst_in;
  logic [BW-1:0]  out_word;
  logic           output_valid;
  logic [W-1:0]   byte_out;
  logic           byte_valid;
  logic           byte_ready;
  logic           byte_last;
  logic [L2D:0]   fill_level;
  logic           overflow;
  logic [DCW-1:0] dropped_count;
  logic           clear_overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: queued words, remaining bytes of the word being shifted out.
  logic [BW-1:0] m_fifo [$];
  logic [W-1:0]  m_cur  [$];
  bit            m_ovf;
  logic [DCW-1:0] m_dc;

  out_stream_unpacker #(
    .IO_DATA_WIDTH  (W),
    .MEM_BW         (BW),
    .LOG2_OF_DEPTH  (L2D),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk            (clk),
    .arst_in        (arst_in),
    .out_word       (out_word),
    .output_valid   (output_valid),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .byte_last      (byte_last),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .dropped_count  (dropped_count),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_cur.delete();
    m_ovf = 1'b0;
    m_dc  = '0;
  endtask

  task automatic model_edge(input bit ov, input logic [BW-1:0] w, input bit rdy, input bit clr);
    bit popq;
    bit drop;
    logic [BW-1:0] h;
    popq = (m_fifo.size() > 0) && (m_cur.size() == 0 || (m_cur.size() == 1 && rdy));
    if (m_cur.size() > 0 && rdy) void'(m_cur.pop_front());
    drop = ov && !(m_fifo.size() < DEPTH || popq);
    if (popq) begin
      h = m_fifo.pop_front();
      for (int k = 0; k < LANES; k++) m_cur.push_back(h[k*W +: W]);
    end
    if (ov && !drop) m_fifo.push_back(w);
    if (drop) begin
      m_ovf = 1'b1;
      m_dc  = clr ? DCW'(1) : ((m_dc == '1) ? m_dc : m_dc + 1'b1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dc  = '0;
    end
  endtask

  task automatic check_outputs();
    chk("byte_valid", 32'(byte_valid), 32'(m_cur.size() > 0));
    if (m_cur.size() > 0) chk("byte_out", 32'(byte_out), 32'(m_cur[0]));
    chk("byte_last", 32'(byte_last), 32'(m_cur.size() == 1));
    chk("fill_level", 32'(fill_level), 32'(m_fifo.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("dropped_count", 32'(dropped_count), 32'(m_dc));
  endtask

  task automatic check_reset_values();
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_last", 32'(byte_last), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_fill_level", 32'(fill_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dropped_count", 32'(dropped_count), 32'd0);
  endtask

  // Called at a negedge: drive, take one rising edge, then check at the next negedge.
  task automatic step(input bit ov, input logic [BW-1:0] w, input bit rdy, input bit clr);
    output_valid   = ov;
    out_word       = w;
    byte_ready     = rdy;
    clear_overflow = clr;
    @(posedge clk);
    model_edge(ov, w, rdy, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (m_cur.size() > 0 || m_fifo.size() > 0); i++)
      step(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 32'(m_cur.size() + m_fifo.size()), 32'd0);
  endtask

  initial begin
    logic [BW-1:0] ramp;
    logic [DCW-1:0] dc_before;

    arst_in        = 1'b1;
    out_word       = '0;
    output_valid   = 1'b0;
    byte_ready     = 1'b0;
    clear_overflow = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk);
    arst_in = 1'b0;

    // Single ramp word: lane k holds k
    for (int k = 0; k < LANES; k++) ramp[k*W +: W] = W'(k);
    step(1'b1, ramp, 1'b1, 1'b0);
    chk("lat_not_yet_valid", 32'(byte_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lat_lane0_valid", 32'(byte_valid), 32'd1);
    chk("lat_lane0_value", 32'(byte_out), 32'h00);
    idle_steps(18, 1'b1);

    // Two back-to-back words, continuous ready
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    idle_steps(36, 1'b1);

    // Eight words under random ready
    for (int n = 0; n < 8; n++) begin
      step(1'b1, rnd_word(), 1'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'($urandom), 1'b0);
    end
    drain();

    // 20 back-to-back words with the consumer stalled
    for (int n = 0; n < 20; n++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    chk("burst_fill", 32'(fill_level), 32'd16);
    chk("burst_overflow", 32'(overflow), 32'd1);
    chk("burst_dropped", 32'(dropped_count), 32'd3);

    // Full FIFO: last-lane acceptance coincident with a new word stores it
    idle_steps(15, 1'b1);
    dc_before = dropped_count;
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    chk("full_pop_store_dropped", 32'(dropped_count), 32'(dc_before));
    chk("full_pop_store_fill", 32'(fill_level), 32'd16);
    // Clear coincident with a drop: the drop wins
    step(1'b1, rnd_word(), 1'b0, 1'b1);
    chk("clr_drop_overflow", 32'(overflow), 32'd1);
    chk("clr_drop_count", 32'(dropped_count), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'd0);
    drain();

    // Reset mid-word with lane 7 pending
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    idle_steps(7, 1'b1);
    chk("pre_rst_lane7", 32'(byte_out), 32'(m_cur[0]));
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    output_valid = 1'b0;
    byte_ready   = 1'b0;
    #2 arst_in = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    arst_in = 1'b0;
    step(1'b1, ramp, 1'b1, 1'b0);
    chk("post_rst_not_yet_valid", 32'(byte_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_lane0", 32'(byte_out), 32'h00);
    idle_steps(18, 1'b1);

    // Random soak: input faster than drain, occasional clears
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 2) == 0), rnd_word(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_stream_unpacker.md
# out_stream_unpacker

Receiver for the accelerator's packed output stream. Captures each MEM_BW-bit output word presented with `output_valid`. The output stream has no backpressure, so every valid word is either buffered or counted as dropped. Buffered words are unpacked into an IO_DATA_WIDTH byte stream with a valid/ready handshake for the host/test side. It is the counterpart of the packer at the chip output and sits directly on the chip's `out`/`output_valid` pins.

## Interface
- IO_DATA_WIDTH, 8, byte width of unpacked lanes
- MEM_BW, 128, packed word width; must be a multiple of IO_DATA_WIDTH
- LOG2_OF_DEPTH, 4, word FIFO depth = 2**LOG2_OF_DEPTH
- DROP_CNT_WIDTH, 16, width of the dropped-word counter

Ports:
- clk  in  1  single clock, all state on rising edge
- arst_in  in  1  asynchronous, active-high reset
- out_word  in  MEM_BW  packed word from chip
- output_valid  in  1  out_word valid this cycle; no ready exists
- byte_out  out  IO_DATA_WIDTH  current unpacked lane
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  consumer accepts byte_out
- byte_last  out  1  byte_out is the final lane of its word
- fill_level  out  LOG2_OF_DEPTH+1  words in FIFO, holding register excluded
- overflow  out  1  sticky: at least one word dropped
- dropped_count  out  DROP_CNT_WIDTH  saturating count of dropped words
- clear_overflow  in  1  synchronous clear of overflow and dropped_count

## Operation
- Lanes: NB_LANES = MEM_BW/IO_DATA_WIDTH (16). Lane k = out_word[IO_DATA_WIDTH*k +: IO_DATA_WIDTH]. Lane 0 is emitted first and lane NB_LANES-1 last.
- Capture: when output_valid=1 at an edge, the word is written to the FIFO if not full, or if full with a pop on the same edge. Otherwise the word is dropped, overflow is set, and dropped_count increments, saturating at all-ones.
- Unpack FSM, two states:
  - IDLE: holding register empty, byte_valid=0. If the FIFO is non-empty: pop, load the holding register, clear lane index, go to SHIFT.
  - SHIFT: byte_valid=1. On a byte_valid&&byte_ready edge, the lane index increments.
    - Acceptance of lane NB_LANES-1 with FIFO non-empty: pop and reload on the same edge, stay in SHIFT, no bubble.
    - Acceptance of lane NB_LANES-1 with FIFO empty: go to IDLE.
- byte_last = byte_valid && (lane index == NB_LANES-1).
- Handshake: byte_out and byte_last are stable while byte_valid=1 and byte_ready=0. byte_valid never drops without acceptance.
- fill_level: +1 on a write, -1 on a pop, unchanged on simultaneous write and pop.
- clear_overflow: zeroes overflow and dropped_count. If a drop occurs on the same edge, the drop wins: overflow=1, dropped_count=1.
- No bypass path. A word written into an empty FIFO while in IDLE is not loaded on the same edge.

## Timing
- Reset values: byte_valid=0, byte_last=0, byte_out=0, fill_level=0, overflow=0, dropped_count=0, FSM=IDLE, lane index=0. FIFO pointers are zeroed and stored words are discarded.
- Reset asserted mid-word drops the remaining lanes. The first post-reset output_valid edge is captured normally.
- Latency from an output_valid edge E0 into an empty block:
  - E0: FIFO write.
  - E1: pop and load.
  - byte_valid=1 after E1.
  - Lane 0 is available 2 cycles after capture.
- Throughput: 1 byte/cycle with byte_ready held high. Sustained input is limited to 1 word per NB_LANES cycles; faster input fills the FIFO and then drops words.
- Full boundary: at fill_level = depth with no pop that edge, output_valid drops the word. If lane NB_LANES-1 is accepted that edge, the word is stored.
- Empty boundary: pop is only issued when fill_level>0. Wrap-around of the pointers is modulo depth, with a separate extra MSB for full/empty.

## Structure
- Shared package (out_stream_unpacker_pkg):
  - typedef for FSM state enum {IDLE, SHIFT}
  - localparam NB_LANES
  - lane index width $clog2(NB_LANES)
- One sub-module: unpacker_word_fifo.
  - Synchronous write/read, MEM_BW wide, depth 2**LOG2_OF_DEPTH, active-high async reset.
  - Exposes full, empty, count, and the registered head word.
- Top level holds the capture/drop logic, overflow counter, holding register, lane mux and FSM.

## Test plan
- Single word 0x0F0E…0100 (lane k = k), byte_ready=1 -> bytes 0x00..0x0F emitted 2 cycles after capture; byte_last only on 0x0F; then IDLE.
- Two consecutive words with byte_ready=1 -> 32 bytes with no gap between lane 15 of word 1 and lane 0 of word 2.
- byte_ready toggled pseudo-randomly over 8 words -> byte stream identical in order to the input lanes; byte_out stable during stalls.
- 20 back-to-back output_valid words (depth 16, byte_ready=0) -> fill_level=16, overflow=1; dropped_count=3 (one word in the holding register, 16 in FIFO).
- Full FIFO, lane 15 accepted on the same edge as output_valid -> word stored, dropped_count unchanged. clear_overflow coincident with a drop -> overflow=1, dropped_count=1.
- arst_in pulsed mid-word (lane 7 pending) -> all outputs to reset values immediately; next word emitted from lane 0 with the correct latency.
